// File: rtl/core_defs.sv
// Shared encodings for the data-memory path: access widths, load/store flag
// and the dmem_ctrl state machine.
package core_defs;

    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_STORE = 1'b1;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_REQ,
        DM_RSP,
        DM_DONE
    } dm_state_e;

endpackage

// File: rtl/dmem_store_align.sv
// Combinational store aligner: byte enables, lane-replicated write data and
// alignment/legality check for one access.
module dmem_store_align
    import core_defs::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_al,
    output logic        misalign
);

    always_comb begin
        be       = 4'b0000;
        wdata_al = wdata;
        misalign = 1'b0;
        case (width)
            MW_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wdata_al = {4{wdata[7:0]}};
            end
            MW_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            MW_WORD: begin
                be       = 4'b1111;
                misalign = |addr_lo;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory responder: accepts one load/store, runs it on the
// simple data bus and returns a one-cycle completion pulse with the raw word.
module dmem_ctrl
    import core_defs::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        rw_i,
    input  logic [1:0]  width_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        fc_flush_i,
    output logic        Dcache_ready_o,
    output logic [31:0] Dcache_data_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    dm_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             drop;

    logic [3:0]  sa_be;
    logic [31:0] sa_wdata;
    logic        sa_mis;

    dmem_store_align u_align (
        .width    (width_i),
        .addr_lo  (addr_i[1:0]),
        .wdata    (wdata_i),
        .be       (sa_be),
        .wdata_al (sa_wdata),
        .misalign (sa_mis)
    );

    // A flush arriving in the same cycle as the response still suppresses it.
    logic drop_now;
    assign drop_now = drop | fc_flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= DM_IDLE;
            cnt            <= '0;
            drop           <= 1'b0;
            Dcache_ready_o <= 1'b0;
            Dcache_data_o  <= '0;
            misalign_o     <= 1'b0;
            err_o          <= 1'b0;
            busy_o         <= 1'b0;
            bus_req_o      <= 1'b0;
            bus_we_o       <= 1'b0;
            bus_addr_o     <= '0;
            bus_be_o       <= '0;
            bus_wdata_o    <= '0;
        end else begin
            Dcache_ready_o <= 1'b0;
            misalign_o     <= 1'b0;
            err_o          <= 1'b0;
            case (state)
                DM_IDLE: begin
                    if (req_i && !fc_flush_i) begin
                        bus_we_o      <= (rw_i == RW_STORE);
                        bus_addr_o    <= {addr_i[31:2], 2'b00};
                        bus_be_o      <= (rw_i == RW_STORE) ? sa_be : 4'b1111;
                        bus_wdata_o   <= sa_wdata;
                        Dcache_data_o <= '0;
                        drop          <= 1'b0;
                        busy_o        <= 1'b1;
                        if (sa_mis) begin
                            state          <= DM_DONE;
                            Dcache_ready_o <= 1'b1;
                            misalign_o     <= 1'b1;
                        end else begin
                            state     <= DM_REQ;
                            bus_req_o <= 1'b1;
                        end
                    end
                end
                DM_REQ: begin
                    // Once granted the transaction must drain; a same-cycle flush becomes a drop.
                    if (bus_gnt_i) begin
                        state     <= DM_RSP;
                        bus_req_o <= 1'b0;
                        cnt       <= '0;
                        drop      <= fc_flush_i;
                    end else if (fc_flush_i) begin
                        state     <= DM_IDLE;
                        bus_req_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end
                end
                DM_RSP: begin
                    cnt  <= cnt + CNT_W'(1);
                    drop <= drop_now;
                    if (bus_rvalid_i) begin
                        if (!bus_we_o) Dcache_data_o <= bus_rdata_i;
                        state          <= DM_DONE;
                        Dcache_ready_o <= !drop_now;
                        err_o          <= bus_err_i && !drop_now;
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state          <= DM_DONE;
                        Dcache_ready_o <= !drop_now;
                        err_o          <= !drop_now;
                    end
                end
                DM_DONE: begin
                    state  <= DM_IDLE;
                    busy_o <= 1'b0;
                    drop   <= 1'b0;
                end
                default: state <= DM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized
// transactions checked against a behavioural access model.
module tb_dmem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, rw_i, fc_flush_i;
    logic [1:0]  width_i;
    logic [31:0] addr_i, wdata_i;
    logic        Dcache_ready_o, misalign_o, err_o, busy_o;
    logic [31:0] Dcache_data_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_rdata_i;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .rw_i           (rw_i),
        .width_i        (width_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .fc_flush_i     (fc_flush_i),
        .Dcache_ready_o (Dcache_ready_o),
        .Dcache_data_o  (Dcache_data_o),
        .misalign_o     (misalign_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .bus_req_o      (bus_req_o),
        .bus_we_o       (bus_we_o),
        .bus_addr_o     (bus_addr_o),
        .bus_be_o       (bus_be_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_gnt_i      (bus_gnt_i),
        .bus_rvalid_i   (bus_rvalid_i),
        .bus_rdata_i    (bus_rdata_i),
        .bus_err_i      (bus_err_i)
    );

    // Reference model: access size in bytes, alignment by modulo, lanes by arithmetic.
    function automatic int acc_size(input logic [1:0] w);
        return (w == 2'd0) ? 0 : (1 << (int'(w) - 1));
    endfunction

    function automatic logic model_mis(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd0) return 1'b1;
        return (a % acc_size(w)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic rw, input logic [1:0] w, input logic [31:0] a);
        int m;
        if (!rw) return 4'hF;
        m = ((1 << acc_size(w)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] d);
        if (w == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
        if (w == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    task automatic idle_inputs();
        req_i = 0; rw_i = 0; width_i = 0; addr_i = 0; wdata_i = 0; fc_flush_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0; bus_err_i = 0;
    endtask

    // One complete transaction: gd REQ cycles before grant, rvalid in RSP cycle rd (rd >= TO: none).
    task automatic run_txn(input logic rw, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] rdat, input logic berr);
        logic        mis, exp_err, exp_rdy, exp_req;
        logic [31:0] exp_data;
        int          lat;
        mis = model_mis(w, a);
        if (mis)          lat = 1;
        else if (rd < TO) lat = gd + rd + 3;
        else              lat = gd + TO + 2;
        exp_err  = !mis && (rd >= TO || berr);
        exp_data = (!mis && !rw && rd < TO) ? rdat : 32'h0;
        @(posedge clk); #1;
        req_i = 1; rw_i = rw; width_i = w; addr_i = a; wdata_i = wd;
        @(posedge clk); #1;
        req_i = 0; addr_i = $urandom; wdata_i = $urandom;
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            bus_gnt_i    = !mis && (cyc == 1 + gd);
            bus_rvalid_i = !mis && (rd < TO) && (cyc == 2 + gd + rd);
            bus_rdata_i  = bus_rvalid_i ? rdat : $urandom;
            bus_err_i    = bus_rvalid_i ? berr : 1'($urandom);
            @(negedge clk);
            exp_rdy = (cyc == lat);
            exp_req = !mis && (cyc <= 1 + gd);
            n_cmp++;
            if (Dcache_ready_o !== exp_rdy) begin
                n_fail++;
                $display("FAIL ready cyc%0d: got %b want %b", cyc, Dcache_ready_o, exp_rdy);
            end
            n_cmp++;
            if (bus_req_o !== exp_req || busy_o !== (cyc <= lat)) begin
                n_fail++;
                $display("FAIL req/busy cyc%0d: got %b/%b want %b/%b", cyc, bus_req_o, busy_o, exp_req, cyc <= lat);
            end
            if (cyc == 1 && !mis) begin
                n_cmp++;
                if (bus_addr_o !== {a[31:2], 2'b00} || bus_be_o !== model_be(rw, w, a) || bus_we_o !== rw) begin
                    n_fail++;
                    $display("FAIL bus_ctl: got addr %h be %b we %b want %h %b %b", bus_addr_o, bus_be_o, bus_we_o,
                             {a[31:2], 2'b00}, model_be(rw, w, a), rw);
                end
                if (rw) begin
                    n_cmp++;
                    if (bus_wdata_o !== model_wdata(w, wd)) begin
                        n_fail++;
                        $display("FAIL bus_wdata: got %h want %h", bus_wdata_o, model_wdata(w, wd));
                    end
                end
            end
            if (cyc == lat) begin
                n_cmp++;
                if (misalign_o !== mis || err_o !== exp_err || Dcache_data_o !== exp_data) begin
                    n_fail++;
                    $display("FAIL completion: got mis %b err %b data %h want %b %b %h", misalign_o, err_o,
                             Dcache_data_o, mis, exp_err, exp_data);
                end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (Dcache_data_o !== exp_data || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold: got data %h busy %b want %h 0", Dcache_data_o, busy_o, exp_data);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({Dcache_ready_o, misalign_o, err_o, busy_o, bus_req_o, bus_we_o, bus_be_o} !== 10'b0 ||
            Dcache_data_o !== 0 || bus_addr_o !== 0 || bus_wdata_o !== 0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy %b busy %b req %b data %h want all zero",
                     Dcache_ready_o, busy_o, bus_req_o, Dcache_data_o);
        end
        rst = 0;
    endtask

    task automatic test_word_load();
        run_txn(1'b0, 2'b11, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (Dcache_data_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_hold: got %h want deadbeef", Dcache_data_o);
        end
    endtask

    task automatic test_byte_store();
        run_txn(1'b1, 2'b01, 32'h203, 32'h0000_00A5, 0, 0, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_misaligned();
        run_txn(1'b1, 2'b10, 32'h301, 32'hCAFE_F00D, 0, 0, 32'h0, 1'b0);
        run_txn(1'b0, 2'b00, 32'h400, 32'h0, 0, 0, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 2'b11, 32'h500, 32'h0, 0, TO, 32'h0, 1'b0);
        run_txn(1'b0, 2'b11, 32'h504, 32'h0, 1, TO - 1, 32'h600D_F00D, 1'b0);
    endtask

    task automatic test_flush_rsp();
        logic [5:0] rdy_seen;
        logic [5:0] busy_seen;
        @(posedge clk); #1;
        req_i = 1; rw_i = 0; width_i = 2'b11; addr_i = 32'h700;
        @(posedge clk); #1; req_i = 0; bus_gnt_i = 1;
        @(negedge clk); rdy_seen[0] = Dcache_ready_o; busy_seen[0] = busy_o;
        @(posedge clk); #1; bus_gnt_i = 0; fc_flush_i = 1;
        @(negedge clk); rdy_seen[1] = Dcache_ready_o; busy_seen[1] = busy_o;
        @(posedge clk); #1; fc_flush_i = 0;
        @(negedge clk); rdy_seen[2] = Dcache_ready_o; busy_seen[2] = busy_o;
        @(posedge clk); #1; bus_rvalid_i = 1; bus_rdata_i = 32'h1111_2222; bus_err_i = 1;
        @(negedge clk); rdy_seen[3] = Dcache_ready_o; busy_seen[3] = busy_o;
        @(posedge clk); #1; bus_rvalid_i = 0; bus_err_i = 0;
        @(negedge clk); rdy_seen[4] = Dcache_ready_o | err_o; busy_seen[4] = busy_o;
        @(posedge clk); #1;
        @(negedge clk); rdy_seen[5] = Dcache_ready_o; busy_seen[5] = busy_o;
        n_cmp++;
        if (rdy_seen !== 6'b0) begin
            n_fail++;
            $display("FAIL flush_rsp_ready: got %b want 000000", rdy_seen);
        end
        n_cmp++;
        if (busy_seen !== 6'b011111) begin
            n_fail++;
            $display("FAIL flush_rsp_busy: got %b want 011111", busy_seen);
        end
        run_txn(1'b0, 2'b10, 32'h802, 32'h0, 0, 1, 32'h0BAD_CAFE, 1'b0);
    endtask

    task automatic test_flush_req_idle();
        @(posedge clk); #1;
        req_i = 1; rw_i = 1; width_i = 2'b11; addr_i = 32'h900; wdata_i = 32'h5;
        @(posedge clk); #1; req_i = 0;
        @(posedge clk); #1; fc_flush_i = 1;
        @(negedge clk);
        n_cmp++;
        if (bus_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_req_pre: got req %b want 1", bus_req_o);
        end
        @(posedge clk); #1; fc_flush_i = 0;
        @(negedge clk);
        n_cmp++;
        if (bus_req_o !== 1'b0 || busy_o !== 1'b0 || Dcache_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_req: got req %b busy %b rdy %b want 0 0 0", bus_req_o, busy_o, Dcache_ready_o);
        end
        @(posedge clk); #1;
        req_i = 1; fc_flush_i = 1; width_i = 2'b00;
        @(posedge clk); #1; idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0 || Dcache_ready_o !== 1'b0 || misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got busy %b rdy %b mis %b want 0 0 0", busy_o, Dcache_ready_o, misalign_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] rdy_seen;
        @(posedge clk); #1;
        req_i = 1; rw_i = 0; width_i = 2'b11; addr_i = 32'hA00;
        @(posedge clk); #1; req_i = 0;
        @(negedge clk);
        n_cmp++;
        if (bus_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got req %b want 1", bus_req_o);
        end
        #1 rst = 1;
        #1;
        n_cmp++;
        if (bus_req_o !== 1'b0 || busy_o !== 1'b0 || bus_addr_o !== 0 || bus_be_o !== 0) begin
            n_fail++;
            $display("FAIL rst_async: got req %b busy %b addr %h be %b want 0", bus_req_o, busy_o, bus_addr_o, bus_be_o);
        end
        @(negedge clk); rst = 0;
        @(posedge clk); #1; bus_rvalid_i = 1; bus_rdata_i = 32'hFFFF_0000;
        @(negedge clk); rdy_seen[0] = Dcache_ready_o;
        @(posedge clk); #1; bus_rvalid_i = 0;
        @(negedge clk); rdy_seen[1] = Dcache_ready_o;
        @(posedge clk); #1;
        @(negedge clk); rdy_seen[2] = Dcache_ready_o | busy_o;
        n_cmp++;
        if (rdy_seen !== 3'b0 || Dcache_data_o !== 0) begin
            n_fail++;
            $display("FAIL late_rvalid: got rdy %b data %h want 000 0", rdy_seen, Dcache_data_o);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        req_i = 1; rw_i = 0; width_i = 2'b00; addr_i = 32'h0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (Dcache_ready_o !== (cyc % 2 == 1) || misalign_o !== (cyc % 2 == 1)) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: got rdy %b mis %b want %b", cyc, Dcache_ready_o, misalign_o, cyc % 2 == 1);
            end
            @(posedge clk);
        end
        #1 idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_txn(1'($urandom), 2'($urandom), a, $urandom, $urandom_range(0, 2),
                    $urandom_range(0, 5), $urandom, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_misaligned();
        test_timeout();
        test_flush_rsp();
        test_flush_req_idle();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the MEM stage. It accepts load/store requests issued at EX/MEM, aligns store data and generates byte enables, and runs one transaction on the simple data bus.
- It returns Dcache_ready and the raw 32-bit word. The MEM stage performs byte/half extraction and sign extension on that word.
- It sits between the ex_mem register outputs and the data-side bus, and is the producer end of the Dcache_ready/Dcache_data interface.

Parameters:
- TIMEOUT_CYC, 255, cycles to wait for bus_rvalid_i after grant before signalling a bus error.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  MEM stage memory access valid (exmem_mtype).
- rw_i  in  1  1 = store, 0 = load.
- width_i  in  2  01 byte, 10 half, 11 word, 00 illegal.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-justified.
- fc_flush_i  in  1  flow-control flush of the MEM stage.
- Dcache_ready_o  out  1  one-cycle completion pulse.
- Dcache_data_o  out  32  raw read word; holds until the next accepted request.
- misalign_o  out  1  pulse coincident with ready for a misaligned or illegal access.
- err_o  out  1  pulse coincident with ready for a bus error or timeout.
- busy_o  out  1  high in any state other than IDLE.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  32  word-aligned address, {addr[31:2], 2'b00}.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  lane-replicated store data.
- bus_gnt_i  in  1  request accepted this cycle.
- bus_rvalid_i  in  1  response valid; sent for both loads and stores.
- bus_rdata_i  in  32  read data.
- bus_err_i  in  1  error, qualified by bus_rvalid_i.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; Dcache_data_o = 0; timeout counter 0; drop flag 0.
- States: IDLE, REQ, RSP, DONE.
- IDLE:
  - With req_i=1 and fc_flush_i=0, register rw, width, addr, be and aligned wdata.
  - If aligned and legal, go to REQ.
  - Otherwise go to DONE with misalign set and no bus activity.
  - A request with fc_flush_i=1 is ignored.
- Misaligned/illegal cases: half with addr[0]=1; word with addr[1:0]!=0; width 00.
- REQ:
  - bus_req_o=1; address, we, be and wdata are stable from registers.
  - On bus_gnt_i go to RSP and clear the counter.
  - fc_flush_i before grant drops the request and returns to IDLE. The bus permits request withdrawal before grant.
- RSP:
  - The counter increments each cycle.
  - On bus_rvalid_i, capture bus_rdata_i (loads only; stores leave the captured word 0), capture bus_err_i, and go to DONE.
  - When the counter reaches TIMEOUT_CYC, go to DONE with err set.
  - rvalid and timeout in the same cycle: rvalid wins and data is captured.
  - fc_flush_i in RSP sets the drop flag. The transaction still drains.
- DONE:
  - Dcache_ready_o=1 for exactly one cycle, with misalign_o/err_o as captured. Dcache_data_o is valid.
  - If the drop flag is set, ready, misalign and err are suppressed.
  - Always return to IDLE next cycle.
  - A new request presented in the DONE cycle is not accepted; it is taken in IDLE.
- Latency with grant and rvalid in the cycle after entry: accept at T0, REQ T1 (gnt), RSP T2 (rvalid), ready T3.
- Minimum misaligned latency: ready at T1.
- Byte enables and write data:
  - byte: be = 4'b0001 << addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata_i[15:0]}}.
  - word: be = 4'b1111; wdata = wdata_i.
  - Loads: be = 4'b1111, bus_we_o=0.
- Dcache_data_o is held after DONE while the MEM stage is stalled. It updates only on a load response capture, and clears to 0 on acceptance of a new request.
- Reset mid-transaction returns to IDLE immediately. Any outstanding bus response arriving afterwards in IDLE is ignored.

Decomposition:
- Shared package (core_defs):
  - width encodings MW_BYTE=2'b01, MW_HALF=2'b10, MW_WORD=2'b11;
  - rw encoding;
  - state enum DM_IDLE/DM_REQ/DM_RSP/DM_DONE.
- Sub-module dmem_store_align: combinational; inputs width, addr[1:0], wdata; outputs be, aligned wdata, misalign.
- The FSM, counter and capture registers live in dmem_ctrl.

Test Plan:
- Word load at addr 0x100, gnt at T1, rvalid at T2 with rdata 0xDEADBEEF -> bus_addr 0x100, be 1111, we 0; ready pulse at T3 with data 0xDEADBEEF; data held while idle.
- Byte store wdata 0x000000A5 at addr 0x203 -> be 1000, bus_wdata 0xA5A5A5A5, bus_addr 0x200, ready one cycle after rvalid, err 0.
- Half store at addr 0x301 -> no bus_req; ready and misalign_o pulse at T1; data 0.
- Load with gnt but no rvalid, TIMEOUT_CYC=4 -> err_o and ready pulse 4 cycles after grant; state returns to IDLE.
- Flush asserted in RSP, then rvalid arrives -> no ready pulse, busy_o falls after drain; next request is accepted normally.
- rst asserted in REQ with bus_req_o=1 -> all outputs 0 asynchronously, state IDLE; a late rvalid produces no ready.
